or_gate_core: RTL and testbench



---
 rtl/or_gate_core_pkg.sv | 11 +
 rtl/or_gate_core_if.sv | 42 ++++
 rtl/or_sat_counter.sv | 35 +++
 rtl/or_gate_core.sv | 72 +++++++
 tb/tb_or_gate_core.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/or_gate_core_pkg.sv
// Shared constants for the or_gate_core slice: default bus and counter widths
// used by the interface and the core so both agree when left unparameterised.
package or_gate_core_pkg;

    // Default operand / result width.
    localparam int OR_DEF_WIDTH = 1;

    // Default width of the saturating hit counter.
    localparam int OR_DEF_CNT_W = 16;

endpackage : or_gate_core_pkg

// File: rtl/or_gate_core_if.sv
// Bus bundle for or_gate_core: operands and qualifier in, combinational and
// registered results out. The master modport is the producer of A/B, the
// slave modport is the core itself.
interface or_gate_core_if
    import or_gate_core_pkg::*;
#(
    parameter int WIDTH = OR_DEF_WIDTH,
    parameter int CNT_W = OR_DEF_CNT_W
);

    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             in_valid;
    logic [WIDTH-1:0] Y;
    logic [WIDTH-1:0] Y_q;
    logic             out_valid;
    logic             any_q;
    logic [CNT_W-1:0] hit_cnt;

    modport master (
        output A,
        output B,
        output in_valid,
        input  Y,
        input  Y_q,
        input  out_valid,
        input  any_q,
        input  hit_cnt
    );

    modport slave (
        input  A,
        input  B,
        input  in_valid,
        output Y,
        output Y_q,
        output out_valid,
        output any_q,
        output hit_cnt
    );

endinterface : or_gate_core_if

// File: rtl/or_sat_counter.sv
// CNT_W-bit up-counter that sticks at its all-ones value instead of wrapping.
// A synchronous clear wins over the increment enable in the same cycle.
module or_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             i_clr,
    input  logic             i_inc,
    output logic [CNT_W-1:0] o_cnt
);

    logic [CNT_W-1:0] r_cnt;
    logic             w_at_max;
    logic             w_do_inc;

    // Counter is saturated once every bit is set.
    assign w_at_max = &r_cnt;

    // Suppress the increment at saturation so the value never rolls over.
    assign w_do_inc = i_inc & ~w_at_max;

    // Counter register: clear has priority, otherwise count or hold.
    always_ff @(posedge clk) begin
        if (i_clr) begin
            r_cnt <= {CNT_W{1'b0}};
        end else if (w_do_inc) begin
            r_cnt <= r_cnt + CNT_W'(1'b1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

    assign o_cnt = r_cnt;

endmodule : or_sat_counter

// File: rtl/or_gate_core.sv
// Bitwise 2-input OR with a live combinational result and a one-cycle
// registered copy carrying a valid flag, a reduction-OR flag and a
// saturating count of valid cycles that produced a nonzero result.
module or_gate_core
    import or_gate_core_pkg::*;
#(
    parameter int WIDTH = OR_DEF_WIDTH,
    parameter int CNT_W = OR_DEF_CNT_W
) (
    input  logic          clk,
    input  logic          rst,
    or_gate_core_if.slave bus
);

    logic [WIDTH-1:0] w_y;
    logic             w_y_any;
    logic             w_hit;
    logic [CNT_W-1:0] w_hit_cnt;

    logic [WIDTH-1:0] r_y_q;
    logic             r_out_valid;
    logic             r_any_q;

    // Combinational OR stays live regardless of clock, reset or qualifier;
    // X/Z on inputs propagate with ordinary OR semantics.
    assign w_y     = bus.A | bus.B;
    assign w_y_any = |w_y;

    // A hit is a qualified cycle whose result has at least one bit set.
    assign w_hit = bus.in_valid & w_y_any;

    // Result register: captures on valid cycles, holds otherwise; reset clears.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_y_q   <= {WIDTH{1'b0}};
            r_any_q <= 1'b0;
        end else if (bus.in_valid) begin
            r_y_q   <= w_y;
            r_any_q <= w_y_any;
        end else begin
            r_y_q   <= r_y_q;
            r_any_q <= r_any_q;
        end
    end

    // Valid flag follows the qualifier one cycle later, one pulse per input.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= bus.in_valid;
        end
    end

    // Reset doubles as the counter clear, so a valid input in a reset cycle
    // is discarded rather than counted.
    or_sat_counter #(
        .CNT_W (CNT_W)
    ) u_hit_cnt (
        .clk   (clk),
        .i_clr (rst),
        .i_inc (w_hit),
        .o_cnt (w_hit_cnt)
    );

    assign bus.Y         = w_y;
    assign bus.Y_q       = r_y_q;
    assign bus.out_valid = r_out_valid;
    assign bus.any_q     = r_any_q;
    assign bus.hit_cnt   = w_hit_cnt;

endmodule : or_gate_core

// File: tb/tb_or_gate_core.sv
// Self-checking bench for or_gate_core. Two instances run side by side:
// a 1-bit core with the default 16-bit counter and a 4-bit core with a
// 3-bit counter so saturation is reachable. Expected values come from a
// behavioural model that tracks hits since the last reset and clamps.
module tb_or_gate_core;

    localparam int MAX1 = 65535;
    localparam int MAX4 = 7;

    logic clk     = 1'b0;
    logic rst     = 1'b0;
    bit   clk_run = 1'b0;

    int n_total = 0;
    int n_bad   = 0;

    // Behavioural model state.
    logic       m1_yq;
    logic       m1_ov;
    logic       m1_any;
    int         m1_hits;
    logic [3:0] m4_yq;
    logic       m4_ov;
    logic       m4_any;
    int         m4_hits;

    // Clock only toggles once the clock-free truth-table phase is over.
    always #5 if (clk_run) clk = ~clk;

    or_gate_core_if #(.WIDTH(1), .CNT_W(16)) bus1 ();
    or_gate_core_if #(.WIDTH(4), .CNT_W(3))  bus4 ();

    or_gate_core #(.WIDTH(1), .CNT_W(16)) u_dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    or_gate_core #(.WIDTH(4), .CNT_W(3)) u_dut4 (
        .clk (clk),
        .rst (rst),
        .bus (bus4.slave)
    );

    function automatic int sat(input int h, input int mx);
        return (h > mx) ? mx : h;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_total++;
        if (obs !== exp_v) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
        end
    endtask

    // Advance the model by one rising edge using the inputs currently applied.
    task automatic model_edge();
        if (rst) begin
            m1_yq = 1'b0; m1_ov = 1'b0; m1_any = 1'b0; m1_hits = 0;
            m4_yq = 4'd0; m4_ov = 1'b0; m4_any = 1'b0; m4_hits = 0;
        end else begin
            m1_ov = bus1.in_valid;
            if (bus1.in_valid) begin
                m1_yq  = bus1.A | bus1.B;
                m1_any = (m1_yq != 1'b0);
                if (m1_any) m1_hits++;
            end
            m4_ov = bus4.in_valid;
            if (bus4.in_valid) begin
                m4_yq  = bus4.A | bus4.B;
                m4_any = (m4_yq != 4'd0);
                if (m4_any) m4_hits++;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".y1"},   32'(bus1.Y),         32'(bus1.A | bus1.B));
        chk({tag, ".yq1"},  32'(bus1.Y_q),       32'(m1_yq));
        chk({tag, ".ov1"},  32'(bus1.out_valid), 32'(m1_ov));
        chk({tag, ".any1"}, 32'(bus1.any_q),     32'(m1_any));
        chk({tag, ".cnt1"}, 32'(bus1.hit_cnt),   32'(sat(m1_hits, MAX1)));
        chk({tag, ".y4"},   32'(bus4.Y),         32'(bus4.A | bus4.B));
        chk({tag, ".yq4"},  32'(bus4.Y_q),       32'(m4_yq));
        chk({tag, ".ov4"},  32'(bus4.out_valid), 32'(m4_ov));
        chk({tag, ".any4"}, 32'(bus4.any_q),     32'(m4_any));
        chk({tag, ".cnt4"}, 32'(bus4.hit_cnt),   32'(sat(m4_hits, MAX4)));
    endtask

    task automatic tick(input string tag);
        @(posedge clk);
        model_edge();
        #1;
        check_all(tag);
    endtask

    initial begin : stim
        logic [3:0] tt;
        logic [1:0] ab;
        tt = 4'b1110;   // Y for AB = 00, 01, 10, 11 (index = {A,B})

        bus1.A = 1'b0; bus1.B = 1'b0; bus1.in_valid = 1'b0;
        bus4.A = 4'd0; bus4.B = 4'd0; bus4.in_valid = 1'b0;
        m1_yq = 1'b0; m1_ov = 1'b0; m1_any = 1'b0; m1_hits = 0;
        m4_yq = 4'd0; m4_ov = 1'b0; m4_any = 1'b0; m4_hits = 0;

        // Clock-free truth table on the 1-bit core.
        for (int i = 0; i < 4; i++) begin
            ab = i[1:0];
            bus1.A = ab[1];
            bus1.B = ab[0];
            #2;
            chk("tt_settle", 32'(bus1.Y), 32'(tt[i]));
            #8;
            chk("tt_stable", 32'(bus1.Y), 32'(tt[i]));
        end

        clk_run = 1'b1;

        // Reset held over two edges with valid all-ones-ish inputs.
        rst = 1'b1;
        bus1.in_valid = 1'b1; bus1.A = 1'b1; bus1.B = 1'b1;
        bus4.in_valid = 1'b1; bus4.A = 4'd1; bus4.B = 4'd1;
        for (int k = 0; k < 2; k++) begin
            tick("rst");
            chk("rst_y1",   32'(bus1.Y),         32'd1);
            chk("rst_cnt4", 32'(bus4.hit_cnt),   32'd0);
            chk("rst_ov4",  32'(bus4.out_valid), 32'd0);
        end
        rst = 1'b0;

        // Directed registered path on the 4-bit core.
        bus1.in_valid = 1'b0;
        bus4.in_valid = 1'b1; bus4.A = 4'b1010; bus4.B = 4'b0101;
        tick("dir");
        chk("dir_yq",  32'(bus4.Y_q),       32'hF);
        chk("dir_ov",  32'(bus4.out_valid), 32'd1);
        chk("dir_any", 32'(bus4.any_q),     32'd1);
        chk("dir_cnt", 32'(bus4.hit_cnt),   32'd1);

        bus4.in_valid = 1'b0;
        tick("hold");
        chk("hold_yq", 32'(bus4.Y_q),       32'hF);
        chk("hold_ov", 32'(bus4.out_valid), 32'd0);

        bus4.in_valid = 1'b1; bus4.A = 4'd0; bus4.B = 4'd0;
        tick("zero");
        chk("zero_yq",  32'(bus4.Y_q),       32'd0);
        chk("zero_any", 32'(bus4.any_q),     32'd0);
        chk("zero_ov",  32'(bus4.out_valid), 32'd1);
        chk("zero_cnt", 32'(bus4.hit_cnt),   32'd1);

        // Saturation of the 3-bit counter.
        rst = 1'b1;
        tick("sat_rst");
        rst = 1'b0;
        bus4.A = 4'd1; bus4.B = 4'd0; bus4.in_valid = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick("sat");
            chk("sat_cnt", 32'(bus4.hit_cnt), 32'((k > 7) ? 7 : k));
        end
        rst = 1'b1;
        tick("sat_clr");
        chk("sat_clr_cnt", 32'(bus4.hit_cnt), 32'd0);
        rst = 1'b0;

        // Reset in the middle of a five-cycle valid burst.
        bus4.A = 4'b0110; bus4.B = 4'b0000; bus4.in_valid = 1'b1;
        bus1.A = 1'b1; bus1.in_valid = 1'b1;
        for (int c = 1; c <= 5; c++) begin
            rst = (c == 3);
            tick("mid");
            if (c == 3) begin
                chk("mid_yq", 32'(bus4.Y_q),       32'd0);
                chk("mid_ov", 32'(bus4.out_valid), 32'd0);
                chk("mid_any", 32'(bus4.any_q),    32'd0);
            end
        end
        rst = 1'b0;
        chk("mid_cnt4", 32'(bus4.hit_cnt), 32'd2);
        chk("mid_cnt1", 32'(bus1.hit_cnt), 32'd2);

        // Randomised traffic with occasional resets.
        for (int n = 0; n < 400; n++) begin
            rst           = ($urandom_range(0, 31) == 0);
            bus1.in_valid = ($urandom_range(0, 3) != 0);
            bus1.A        = 1'($urandom);
            bus1.B        = 1'($urandom);
            bus4.in_valid = ($urandom_range(0, 3) != 0);
            bus4.A        = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            bus4.B        = ($urandom_range(0, 3) == 0) ? 4'd0 : 4'($urandom);
            #1;
            chk("rnd_comb4", 32'(bus4.Y), 32'(bus4.A | bus4.B));
            tick("rnd");
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_or_gate_core
